// File: rtl/led_sched_pkg.sv
// Shared types, default channel periods and width helper for the LED blink scheduler.
// Pure declarations: no latency, no flow control.
package led_sched_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_N = 8;
    localparam logic [7:0] DEF_PERIODS [DEF_N] = '{
        8'd10, 8'd25, 8'd50, 8'd80, 8'd120, 8'd150, 8'd180, 8'd200
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: half-period counter, shadow/active period pair and LED flop.
// Toggles on the edge following a base tick; always accepts writes, no backpressure.
module led_channel
    import led_sched_pkg::*;
#(
    parameter int            PW  = 8,
    parameter logic [PW-1:0] DEF = '0
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          tick,
    input  logic          run,
    input  logic          sync,
    input  logic          wr,
    input  logic [PW-1:0] wdata,
    output logic          led
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] cnt;
    logic [PW-1:0] shadow;
    logic [PW-1:0] active;
    logic [PW-1:0] shadow_nxt;

    assign shadow_nxt = wr ? wdata : shadow;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            cnt    <= '0;
            shadow <= DEF;
            active <= DEF;
            led    <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (!run) begin
                cnt <= '0;
                led <= 1'b0;
                if (wr) active <= wdata;
            end else if (sync) begin
                cnt    <= '0;
                led    <= 1'b0;
                active <= shadow_nxt;
            end else if (tick) begin
                if (active == '0) begin
                    cnt    <= '0;
                    led    <= 1'b0;
                    active <= shadow;
                end else if (cnt == active - ONE) begin
                    // A toggle into a disabled period parks the LED low rather than high.
                    cnt    <= '0;
                    led    <= (shadow == '0) ? 1'b0 : ~led;
                    active <= shadow;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shared prescaler, start/stop/sync FSM and CH blink channels on one time base.
// Base tick every TICK_DIV cycles in RUN; LED updates one cycle after tick; no backpressure.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter  int TICK_DIV = 500000,
    parameter  int CH       = 8,
    parameter  int PW       = 8,
    localparam int AW       = (CH > 1) ? clog2(CH) : 1,
    localparam int PCW      = clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          start,
    input  logic          stop,
    input  logic          sync,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [PW-1:0] cfg_period,
    output logic [CH-1:0] led,
    output logic          tick,
    output logic          running
);

    localparam logic [PCW-1:0] PLAST = PCW'(TICK_DIV - 1);

    logic [1:0]     rst_sync;
    logic           rst_n;
    state_t         state;
    logic [PCW-1:0] pcnt;
    logic           in_run;
    logic           clr;

    // Assert immediately, release aligned to clk.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            pcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (start && !stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        pcnt    <= '0;
                    end else if (sync || pcnt == PLAST) begin
                        pcnt <= '0;
                    end else begin
                        pcnt <= pcnt + PCW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    pcnt    <= '0;
                end
            endcase
        end
    end

    assign in_run = (state == RUN);
    assign tick   = in_run && (pcnt == PLAST);
    // stop and sync both realign the channels; stop additionally drops the FSM to IDLE.
    assign clr    = in_run && (stop || sync);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (int'(cfg_addr) == i);

        led_channel #(
            .PW  (PW),
            .DEF (PW'(DEF_PERIODS[i % DEF_N]))
        ) u_ch (
            .clk   (clk),
            .aclr  (rst_n),
            .tick  (tick),
            .run   (in_run),
            .sync  (clr),
            .wr    (wr),
            .wdata (cfg_period),
            .led   (led[i])
        );
    end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Sequencer for the LED flashing board: one shared prescaler produces a base tick, and eight per-channel blink counters derive their toggle times from that tick. Channel half-periods are programmable at run time through a single-cycle write port. Global start/stop/sync controls replace the free-running per-LED dividers, so all LEDs share one time base and can be phase-aligned.

## Interface
- TICK_DIV, 500000: clk cycles per base tick (50 MHz → 10 ms tick); legal range ≥ 2.
- CH, 8: number of LED channels.
- PW, 8: period width in bits; a period is a half-period in ticks.
- clk  in  1  system clock.
- aclr  in  1  reset, asynchronous, active-low.
- start  in  1  pulse: IDLE→RUN.
- stop  in  1  pulse: RUN→IDLE.
- sync  in  1  pulse: in RUN, realign all channel phases.
- cfg_we  in  1  single-cycle period write strobe.
- cfg_addr  in  clog2(CH)  channel index; values ≥ CH are ignored.
- cfg_period  in  PW  new half-period in ticks; 0 = channel disabled.
- led  out  CH  LED drive, registered.
- tick  out  1  base tick pulse (RUN only).
- running  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN. Reset → IDLE.
- Transitions: IDLE + start → RUN. RUN + stop → IDLE. start in RUN is ignored. stop in IDLE is ignored. stop and start in the same cycle: stop wins, so IDLE results from either state.
- IDLE behaviour:
  - Prescaler pcnt, channel counters cnt[i] and led all held at 0.
  - cfg writes update both shadow[i] and active[i] immediately.
- RUN prescaler: pcnt counts 0..TICK_DIV-1 and wraps. tick = (pcnt == TICK_DIV-1), combinational from registers.
- RUN channel i with active[i] = P ≠ 0: on each tick, if cnt[i] == P-1, then led[i] toggles, cnt[i] ← 0 and active[i] ← shadow[i]. Otherwise cnt[i] increments.
- RUN channel i with active[i] = 0: led[i] is forced to 0, cnt[i] = 0, and active[i] ← shadow[i] on the next tick.
- RUN cfg write: updates shadow[i] only. The new value takes effect at the channel's next toggle, never mid-period. A second write before that toggle overwrites the first.
- cfg_we coincident with a toggle of the same channel: the toggle loads the old shadow, and the write lands in shadow for the following period.
- sync in RUN: pcnt, all cnt and all led ← 0; active ← shadow. sync wins over a coincident tick. sync in IDLE has no effect.
- On the RUN→IDLE edge: active ← shadow and all counters are cleared.
- Reset values:
  - led = 0, tick = 0, running = 0, pcnt = 0, cnt = 0.
  - shadow and active = package defaults: 10, 25, 50, 80, 120, 150, 180, 200.
- Width rules: cnt is PW bits and pcnt is clog2(TICK_DIV) bits. Compare against P-1 only when P ≠ 0.

## Timing
- Start edge E0: first tick is high in the cycle at E0 + TICK_DIV-1; subsequent ticks every TICK_DIV cycles.
- Channel with period P:
  - First led toggle is visible TICK_DIV·P cycles after E0.
  - Full blink period is 2·P·TICK_DIV cycles.
- led changes only on a clk edge where tick is high (or on a sync/stop edge).
- stop: led = 0 and running = 0 one cycle after the stop is sampled.
- aclr is asserted asynchronously and clears immediately, including mid-RUN. Release must be synchronous to clk; the block resumes in IDLE with default periods.

## Structure
- Package led_sched_pkg contains:
  - typedef enum {IDLE, RUN} for the FSM state.
  - Localparam array of the CH default periods.
  - clog2 helper function.
- Sub-module led_channel contains: cnt, shadow, active and the led flop. Inputs are tick, run, sync, wr and wdata.
- The top level holds the FSM, the prescaler, address decode and CH instances of led_channel.

## Test plan
- Reset values: TICK_DIV=4, release aclr → led=0, running=0, and readback of channel 0 active = 10.
- Basic blink: TICK_DIV=4, write ch0 = 2 in IDLE, then start → led[0] rises 8 cycles after start, falls 8 cycles later; tick period is 4 cycles.
- Deferred write: in RUN, ch1 = 3, write 1 mid-period → current half-period still 12 cycles; next half-periods are 4 cycles.
- Disable channel: write 0 to ch2 in RUN → led[2] continues to its next toggle, then is held at 0. Writing 2 afterwards → it resumes toggling 2 ticks after the next tick.
- Simultaneous events:
  - start+stop in the same cycle → stays IDLE.
  - sync coincident with tick → all led=0 and pcnt=0, no toggle.
- Mid-run reset: assert aclr asynchronously between clock edges in RUN → outputs are 0 immediately; after release, state is IDLE with default periods restored.
